// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 key-schedule controller: FSM states,
// key-register mode encodings, FK constants and the CK byte step.
package sm4_pkg;

    // Controller states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StRound = 2'd2,
        StDone  = 2'd3
    } sm4_state_e;

    // Key-register mode encodings driven on ctrl_k
    localparam logic [1:0] CtrlKLoad = 2'd0;  // load / idle
    localparam logic [1:0] CtrlKLo   = 2'd1;  // bits 0-12
    localparam logic [1:0] CtrlKMid  = 2'd3;  // bits 13-22
    localparam logic [1:0] CtrlKHi   = 2'd2;  // bits 23-31

    // Last bit index of each ctrl_k band
    localparam logic [4:0] LoBandLast  = 5'd12;
    localparam logic [4:0] MidBandLast = 5'd22;

    // Family key constants FK0..FK3
    localparam logic [31:0] Fk0 = 32'hA3B1_BAC6;
    localparam logic [31:0] Fk1 = 32'h56AA_3350;
    localparam logic [31:0] Fk2 = 32'h677D_9197;
    localparam logic [31:0] Fk3 = 32'hB270_22DC;

    // CK byte j of round r is ((4r + j) * CkStep) mod 256
    localparam int unsigned CkStep = 7;

    // Last counter values
    localparam logic [4:0] LastBit   = 5'd31;
    localparam logic [4:0] LastRound = 5'd31;
    localparam logic [1:0] LastWord  = 2'd3;

    // Select the FK word for user-key word w
    function automatic logic [31:0] fk_word(input logic [1:0] w);
        logic [31:0] word;
        unique case (w)
            2'd0: word = Fk0;
            2'd1: word = Fk1;
            2'd2: word = Fk2;
            2'd3: word = Fk3;
        endcase
        return word;
    endfunction

    // Key-register mode for a given bit position within a round
    function automatic logic [1:0] ctrl_k_for_bit(input logic [4:0] b);
        logic [1:0] mode;
        if (b <= LoBandLast) begin
            mode = CtrlKLo;
        end else if (b <= MidBandLast) begin
            mode = CtrlKMid;
        end else begin
            mode = CtrlKHi;
        end
        return mode;
    endfunction

endpackage

// File: rtl/sm4_ck_gen.sv
// Serial CK constant generator: returns bit (31 - bit_idx) of CK[round_idx].
// Bytes are formed arithmetically, so no per-round table is stored.
module sm4_ck_gen
    import sm4_pkg::*;
(
    input  logic [4:0] round_idx,
    input  logic [4:0] bit_idx,
    output logic       ck
);

    logic [6:0] byte_sel;
    logic [9:0] prod;
    logic [7:0] ck_byte;

    // Byte index 4r+j with j = bit_idx[4:3] (MSB byte first), then pick the bit MSB-first
    always_comb begin
        byte_sel = {round_idx, bit_idx[4:3]};
        prod     = {3'b000, byte_sel} * 10'(CkStep);
        ck_byte  = prod[7:0];
        ck       = ck_byte[~bit_idx[2:0]];
    end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule sequencer. Streams the 128-bit user key in (LOAD), then
// walks 32 rounds x 32 bits (ROUND), emitting serial FK/CK constant bits and
// the key-register mode. All outputs come straight from flops.
// Optional build macro SM4_ABORT_EN adds an abort input that cancels a run.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef SM4_ABORT_EN
    input  logic       abort,
`endif
    output logic       key_req,
    output logic       fk,
    output logic       ck,
    output logic [1:0] ctrl_k,
    output logic [4:0] round_idx,
    output logic [4:0] bit_idx,
    output logic       busy,
    output logic       done
);

    sm4_state_e state_q, state_d;
    logic [1:0] word_q, word_d;
    logic [4:0] round_q, round_d;
    logic [4:0] bit_q, bit_d;

    logic       key_req_q, key_req_d;
    logic       fk_q, fk_d;
    logic       ck_q, ck_d;
    logic [1:0] ctrl_k_q, ctrl_k_d;
    logic [4:0] round_idx_q, round_idx_d;
    logic [4:0] bit_idx_q, bit_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic        ck_next;
    logic [31:0] fk_sel;

    // CK bit for the position the counters move to on the next edge
    sm4_ck_gen u_ck_gen (
        .round_idx (round_d),
        .bit_idx   (bit_d),
        .ck        (ck_next)
    );

    // Next state and counters
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        round_d = round_q;
        bit_d   = bit_q;

        case (state_q)
            StIdle: begin
                word_d  = 2'd0;
                round_d = 5'd0;
                bit_d   = 5'd0;
                if (start) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
`ifdef SM4_ABORT_EN
                if (abort) begin
                    state_d = StIdle;
                    word_d  = 2'd0;
                    round_d = 5'd0;
                    bit_d   = 5'd0;
                end else
`endif
                begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == LastBit) begin
                        bit_d = 5'd0;
                        if (word_q == LastWord) begin
                            state_d = StRound;
                            word_d  = 2'd0;
                            round_d = 5'd0;
                        end else begin
                            word_d = word_q + 2'd1;
                        end
                    end
                end
            end

            StRound: begin
`ifdef SM4_ABORT_EN
                if (abort) begin
                    state_d = StIdle;
                    word_d  = 2'd0;
                    round_d = 5'd0;
                    bit_d   = 5'd0;
                end else
`endif
                begin
                    bit_d = bit_q + 5'd1;
                    if (bit_q == LastBit) begin
                        bit_d = 5'd0;
                        if (round_q == LastRound) begin
                            state_d = StDone;
                            round_d = 5'd0;
                        end else begin
                            round_d = round_q + 5'd1;
                        end
                    end
                end
            end

            StDone: begin
                // start is not sampled here, so it cannot queue a new run
                state_d = StIdle;
                word_d  = 2'd0;
                round_d = 5'd0;
                bit_d   = 5'd0;
            end

            default: begin
                state_d = StIdle;
                word_d  = 2'd0;
                round_d = 5'd0;
                bit_d   = 5'd0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next state so they can be registered
    always_comb begin
        key_req_d   = 1'b0;
        fk_d        = 1'b0;
        ck_d        = 1'b0;
        ctrl_k_d    = CtrlKLoad;
        round_idx_d = 5'd0;
        bit_idx_d   = 5'd0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        fk_sel      = fk_word(word_d);

        case (state_d)
            StLoad: begin
                key_req_d = 1'b1;
                busy_d    = 1'b1;
                fk_d      = fk_sel[~bit_d];
                bit_idx_d = bit_d;
            end
            StRound: begin
                busy_d      = 1'b1;
                ctrl_k_d    = ctrl_k_for_bit(bit_d);
                ck_d        = ck_next;
                round_idx_d = round_d;
                bit_idx_d   = bit_d;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, counters and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_q      <= 2'd0;
            round_q     <= 5'd0;
            bit_q       <= 5'd0;
            key_req_q   <= 1'b0;
            fk_q        <= 1'b0;
            ck_q        <= 1'b0;
            ctrl_k_q    <= CtrlKLoad;
            round_idx_q <= 5'd0;
            bit_idx_q   <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            round_q     <= round_d;
            bit_q       <= bit_d;
            key_req_q   <= key_req_d;
            fk_q        <= fk_d;
            ck_q        <= ck_d;
            ctrl_k_q    <= ctrl_k_d;
            round_idx_q <= round_idx_d;
            bit_idx_q   <= bit_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign key_req   = key_req_q;
    assign fk        = fk_q;
    assign ck        = ck_q;
    assign ctrl_k    = ctrl_k_q;
    assign round_idx = round_idx_q;
    assign bit_idx   = bit_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Scoreboard bench for sm4_key_sched_ctrl. The driver advances a phase-count
// reference model each cycle and queues the expected outputs; a monitor pops
// and compares one entry per clock. Also exercises SM4_ABORT_EN when defined.
module tb_sm4_key_sched_ctrl;

`ifdef SM4_ABORT_EN
    localparam bit AbortBuilt = 1'b1;
`else
    localparam bit AbortBuilt = 1'b0;
`endif

    localparam int LoadLen  = 128;
    localparam int RoundLen = 1024;
    localparam int BusyLen  = LoadLen + RoundLen;  // phase 1..1152 busy, 1153 done

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
`ifdef SM4_ABORT_EN
    logic abort = 1'b0;
`endif

    logic       key_req, fk, ck, busy, done;
    logic [1:0] ctrl_k;
    logic [4:0] round_idx, bit_idx;

    always #5 clk = ~clk;

    sm4_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SM4_ABORT_EN
        .abort     (abort),
`endif
        .key_req   (key_req),
        .fk        (fk),
        .ck        (ck),
        .ctrl_k    (ctrl_k),
        .round_idx (round_idx),
        .bit_idx   (bit_idx),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [6:0] vec;      // {busy, done, key_req, fk, ck, ctrl_k}
        logic       chk_idx;  // round/bit indices defined for this cycle
        logic [9:0] idx;      // {round_idx, bit_idx}
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          t_model  = 0;  // 0 idle, 1..1152 busy cycle number, 1153 done
    int          model_done_cnt = 0;
    logic [31:0] fk_tab [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    // Monitor statistics (written only by the monitor)
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          bb_gap = 0;
    int          busy_run = 0;
    int          last_busy_len = 0;
    int          kr_pos = 0;
    int          last_kr_len = 0;
    logic        first_fk = 1'b0;
    logic        fk32 = 1'b1;
    logic [31:0] ck_s0 = '0;
    logic [31:0] ck_s1 = '0;
    int          c1 = 0, c3 = 0, c2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // CK[r] as a 32-bit word: byte j = ((4r+j)*7) mod 256, byte 0 most significant
    function automatic logic [31:0] ck_word(input int r);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) begin
            w = (w << 8) | 32'(((4 * r + j) * 7) % 256);
        end
        return w;
    endfunction

    // Expected outputs while the model sits at phase t
    function automatic exp_t expect_for(input int t);
        exp_t        e;
        logic        e_busy = 1'b0, e_done = 1'b0, e_kr = 1'b0, e_fk = 1'b0, e_ck = 1'b0;
        logic [1:0]  e_ck_mode = 2'd0;
        logic [31:0] w;
        int          k, r, b;
        e = '0;
        if (t == 0) begin
            e.chk_idx = 1'b1;
        end else if (t <= LoadLen) begin
            k      = t - 1;
            w      = fk_tab[k / 32];
            b      = k % 32;
            e_busy = 1'b1;
            e_kr   = 1'b1;
            e_fk   = w[31 - b];
        end else if (t <= BusyLen) begin
            k      = t - LoadLen - 1;
            r      = k / 32;
            b      = k % 32;
            w      = ck_word(r);
            e_busy = 1'b1;
            e_ck   = w[31 - b];
            e_ck_mode = (b < 13) ? 2'd1 : ((b < 23) ? 2'd3 : 2'd2);
            e.chk_idx = 1'b1;
            e.idx     = {5'(r), 5'(b)};
        end else begin
            e_done = 1'b1;
        end
        e.vec = {e_busy, e_done, e_kr, e_fk, e_ck, e_ck_mode};
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the next edge
    task automatic step(input logic s, input logic r, input logic a);
        @(negedge clk);
        start = s;
        rst_n = r;
`ifdef SM4_ABORT_EN
        abort = a;
`endif
        if (!r) begin
            t_model = 0;
        end else if (t_model == 0) begin
            t_model = s ? 1 : 0;
        end else if (t_model <= BusyLen) begin
            t_model = (a && AbortBuilt) ? 0 : t_model + 1;
        end else begin
            t_model = 0;
        end
        if (t_model == BusyLen + 1) model_done_cnt++;
        exp_q.push_back(expect_for(t_model));
    endtask

    // Monitor: compare every cycle, gather run statistics
    initial begin
        exp_t e;
        logic prev_busy = 1'b0;
        logic prev_kr   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 32'({busy, done, key_req, fk, ck, ctrl_k}), 32'(e.vec));
                if (e.chk_idx) check("round_bit_idx", 32'({round_idx, bit_idx}), 32'(e.idx));
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (busy === 1'b1 && !prev_busy) begin
                busy_run = 0;
                if (last_done_cyc > 0) bb_gap = cyc - last_done_cyc;
            end
            if (busy === 1'b1) busy_run++;
            if (busy !== 1'b1 && prev_busy) last_busy_len = busy_run;
            if (key_req === 1'b1) begin
                if (!prev_kr) kr_pos = 0;
                if (kr_pos == 0) first_fk = fk;
                if (kr_pos == 32) fk32 = fk;
                kr_pos++;
            end else if (prev_kr) begin
                last_kr_len = kr_pos;
            end
            if (busy === 1'b1 && key_req === 1'b0) begin
                if (round_idx == 5'd0) begin
                    if (bit_idx == 5'd0) begin
                        c1 = 0;
                        c3 = 0;
                        c2 = 0;
                    end
                    ck_s0 = {ck_s0[30:0], ck};
                    if (ctrl_k == 2'd1) c1++;
                    else if (ctrl_k == 2'd3) c3++;
                    else if (ctrl_k == 2'd2) c2++;
                end
                if (round_idx == 5'd1) ck_s1 = {ck_s1[30:0], ck};
            end
            prev_busy = (busy === 1'b1);
            prev_kr   = (key_req === 1'b1);
        end
    end

    initial begin
        int d0;
        int m0;

        // Reset, with start held high to show it is ignored under reset
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);

        // Full run with random (and one forced mid-ROUND) start pulses that must be ignored
        d0 = done_cnt;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1300 && t_model != 0; i++) begin
            step((t_model == 600) || ($urandom_range(0, 5) == 0), 1'b1, 1'b0);
        end
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("run1_done_count", 32'(done_cnt - d0), 32'd1);
        check("run1_busy_cycles", 32'(last_busy_len), 32'd1152);
        check("run1_keyreq_cycles", 32'(last_kr_len), 32'd128);
        check("run1_first_fk", 32'(first_fk), 32'd1);
        check("run1_fk_load32", 32'(fk32), 32'd0);
        check("ck_stream_round0", ck_s0, 32'h00070E15);
        check("ck_stream_round1", ck_s1, 32'h1C232A31);
        check("ctrl_k_count_1", 32'(c1), 32'd13);
        check("ctrl_k_count_3", 32'(c3), 32'd10);
        check("ctrl_k_count_2", 32'(c2), 32'd9);

        // Reset at ROUND round 5 bit 7: no done may follow
        d0 = done_cnt;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && t_model != LoadLen + 5 * 32 + 7 + 1; i++) begin
            step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        repeat (1300) step(1'b0, 1'b1, 1'b0);
        check("reset_mid_round_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SM4_ABORT_EN
        // Abort at LOAD cycle 50, then a fresh full run
        d0 = done_cnt;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && t_model != 51; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1300 && t_model != 0; i++) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("after_abort_done_count", 32'(done_cnt - d0), 32'd1);
        check("after_abort_busy_cycles", 32'(last_busy_len), 32'd1152);
`endif

        // Back-to-back: start held high continuously
        d0 = done_cnt;
        m0 = model_done_cnt;
        repeat (2400) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1300 && t_model != 0; i++) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("b2b_done_count", 32'(done_cnt - d0), 32'(model_done_cnt - m0));
        check("b2b_gap_done_to_busy", 32'(bb_gap), 32'd2);

        // Random start / reset / abort traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 399) != 0,
                 AbortBuilt && ($urandom_range(0, 299) == 0));
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
